dram_share_arbiter: RTL and testbench

// - Round-robin arbiter sharing the single data RAM between the N processor cores of top_control_8.
// - Serialises core load/store requests and returns read data to the requesting core only.
// - Yields the RAM to the external load/readback port (start_3 / start_4 phases) via ext_en.
// - Sits between the core array and the DRAM instance, replacing the direct core-0 connection.

---
 rtl/dram_arb_pkg.sv | 13 +
 rtl/dram_share_arbiter_rr_picker.sv | 30 +++
 rtl/dram_share_arbiter.sv | 130 +++++++++++++
 tb/tb_dram_share_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared state encoding and RAM timing constant for the DRAM share arbiter.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        EXT    = 2'd3
    } arb_state_t;

    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/dram_share_arbiter_rr_picker.sv
// Round-robin winner search: first set request at ptr, ptr+1, ... (mod N_CORES).
module rr_picker
    import dram_arb_pkg::*;
#(
    parameter  int N_CORES = 8,
    localparam int PTR_W   = $clog2(N_CORES)
) (
    input  logic [N_CORES-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_o
);

    logic [PTR_W-1:0] idx;

    // N_CORES is a power of two, so the index wraps by truncation.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_CORES; i++) begin
            idx = ptr_i + PTR_W'(i);
            if (!any_o && req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/dram_share_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between N cores,
// with an override that hands the RAM to the external load/readback port.
module dram_share_arbiter
    import dram_arb_pkg::*;
#(
    parameter int N_CORES = 8,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic [N_CORES-1:0]          req_i,
    input  logic [N_CORES-1:0]          we_i,
    input  logic [N_CORES*ADDR_W-1:0]   addr_i,
    input  logic [N_CORES*DATA_W-1:0]   wdata_i,
    output logic [N_CORES-1:0]          gnt_o,
    output logic [N_CORES-1:0]          rvalid_o,
    output logic [DATA_W-1:0]           rdata_o,
    input  logic                        ext_en_i,
    input  logic                        ext_we_i,
    input  logic                        ext_re_i,
    input  logic [ADDR_W-1:0]           ext_addr_i,
    input  logic [DATA_W-1:0]           ext_wdata_i,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic                        mem_we_o,
    output logic                        mem_re_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic                        busy_o
);

    localparam int PTR_W = $clog2(N_CORES);

    arb_state_t             state_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       sel_q;
    logic [N_CORES-1:0]     gnt_q;
    logic [N_CORES-1:0]     rvalid_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic                   mem_we_q;
    logic                   mem_re_q;
    logic [DATA_W-1:0]      mem_wdata_q;
    logic [RAM_RD_LAT-1:0]  resp_q;

    logic [PTR_W-1:0]       winner;
    logic                   any_req;
    logic [ADDR_W-1:0]      core_addr_d;
    logic [DATA_W-1:0]      core_wdata_d;
    logic                   core_we_d;
    logic [N_CORES-1:0]     sel_oh_d;
    logic                   ext_mode;

    rr_picker #(.N_CORES(N_CORES)) u_picker (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    assign core_addr_d  = addr_i[int'(sel_q) * ADDR_W +: ADDR_W];
    assign core_wdata_d = wdata_i[int'(sel_q) * DATA_W +: DATA_W];
    assign core_we_d    = we_i[sel_q];
    assign sel_oh_d     = N_CORES'(1) << sel_q;
    assign ext_mode     = (state_q == EXT);

    // Strobes are registered one cycle behind the state that decides them;
    // resp_q tracks read data arriving RAM_RD_LAT cycles after the strobe.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            resp_q      <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            resp_q   <= RAM_RD_LAT'({resp_q, (state_q == RESP)});
            if (resp_q[RAM_RD_LAT-1]) begin
                rdata_q  <= mem_rdata_i;
                rvalid_q <= sel_oh_d;
            end
            unique case (state_q)
                ARB: begin
                    if (ext_en_i) begin
                        state_q <= EXT;
                    end else if (any_req) begin
                        sel_q   <= winner;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt_q       <= sel_oh_d;
                    mem_addr_q  <= core_addr_d;
                    mem_we_q    <= core_we_d;
                    mem_re_q    <= ~core_we_d;
                    mem_wdata_q <= core_wdata_d;
                    ptr_q       <= sel_q + PTR_W'(1);
                    state_q     <= core_we_d ? ARB : RESP;
                end
                RESP: begin
                    state_q <= ARB;
                end
                EXT: begin
                    rdata_q <= mem_rdata_i;
                    if (!ext_en_i) state_q <= ARB;
                end
            endcase
        end
    end

    assign mem_addr_o  = ext_mode ? ext_addr_i  : mem_addr_q;
    assign mem_we_o    = ext_mode ? ext_we_i    : mem_we_q;
    assign mem_re_o    = ext_mode ? ext_re_i    : mem_re_q;
    assign mem_wdata_o = ext_mode ? ext_wdata_i : mem_wdata_q;
    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != ARB);

endmodule

// File: tb/tb_dram_share_arbiter.sv
// Directed bench for dram_share_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dram_share_arbiter;

    localparam int N = 8;
    localparam int AW = 9;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            ext_en, ext_we, ext_re;
    logic [AW-1:0]   ext_addr;
    logic [DW-1:0]   ext_wdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_we, mem_re;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            busy;

    logic [DW-1:0]   ram [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    int c4;

    always #5 clk = ~clk;

    dram_share_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock_i(clk), .reset_i(rst),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .ext_en_i(ext_en), .ext_we_i(ext_we), .ext_re_i(ext_re),
        .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int i, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r;
        we[i]  = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        set_core(i, 1'b1, 1'b0, a, '0);
        tick();
        tick();
        chk($sformatf("rd_gnt_c%0d", i), gnt, N'(1) << i);
        req[i] = 1'b0;
        tick();
        chk($sformatf("rd_early_rvalid_c%0d", i), rvalid, '0);
        tick();
        chk($sformatf("rd_rvalid_c%0d", i), rvalid, N'(1) << i);
        chk($sformatf("rd_data_c%0d", i), rdata, exp);
    endtask

    task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_core(i, 1'b1, 1'b1, a, d);
        tick();
        tick();
        chk($sformatf("wr_gnt_c%0d", i), gnt, N'(1) << i);
        req[i] = 1'b0;
        tick();
    endtask

    task automatic ext_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        tick();
        ext_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        ext_en = 1'b0; ext_we = 1'b0; ext_re = 1'b0; ext_addr = '0; ext_wdata = '0;
        tick();
        tick();
        chk("rst_gnt", gnt, '0);
        chk("rst_rvalid", rvalid, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Preload RAM through the external port.
        ext_en = 1'b1;
        tick();
        chk("ext_busy", busy, 1'b1);
        ext_write(9'd20, 16'h00AB);
        ext_write(9'd40, 16'h5555);
        ext_en = 1'b0;
        tick();
        chk("ext_exit_busy", busy, 1'b0);

        // Core 3 read: gnt two edges after req, rvalid two edges later.
        set_core(3, 1'b1, 1'b0, 9'd20, '0);
        tick();
        chk("c3_busy", busy, 1'b1);
        chk("c3_no_gnt_yet", gnt, '0);
        tick();
        chk("c3_gnt", gnt, 8'h08);
        chk("c3_mem_re", mem_re, 1'b1);
        chk("c3_mem_addr", mem_addr, 9'd20);
        req[3] = 1'b0;
        tick();
        chk("c3_gnt_pulse", gnt, '0);
        chk("c3_no_rvalid_yet", rvalid, '0);
        tick();
        chk("c3_rvalid", rvalid, 8'h08);
        chk("c3_rdata", rdata, 16'h00AB);
        tick();
        chk("c3_rvalid_pulse", rvalid, '0);
        chk("c3_rdata_hold", rdata, 16'h00AB);

        // All 8 cores write addr i <- 100+i together; expect order 0..7 every 2 cycles.
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b1, AW'(i), DW'(100 + i));
        for (int k = 0; k < N; k++) begin
            tick();
            chk($sformatf("wr_all_gap%0d", k), gnt, '0);
            tick();
            chk($sformatf("wr_all_gnt%0d", k), gnt, N'(1) << k);
            chk($sformatf("wr_all_we%0d", k), mem_we, 1'b1);
            chk($sformatf("wr_all_wdata%0d", k), mem_wdata, DW'(100 + k));
            req[k] = 1'b0;
        end
        for (int i = 0; i < N; i++) do_read(i, AW'(i), DW'(100 + i));

        // Pointer to 6 via a core 5 write, then cores 0,1,7 -> order 7,0,1.
        do_write(5, 9'd50, 16'h0505);
        set_core(0, 1'b1, 1'b1, 9'd30, 16'h0030);
        set_core(1, 1'b1, 1'b1, 9'd31, 16'h0031);
        set_core(7, 1'b1, 1'b1, 9'd37, 16'h0037);
        tick(); tick();
        chk("wrap_gnt_7", gnt, 8'h80);
        req[7] = 1'b0;
        tick(); tick();
        chk("wrap_gnt_0", gnt, 8'h01);
        req[0] = 1'b0;
        tick(); tick();
        chk("wrap_gnt_1", gnt, 8'h02);
        req[1] = 1'b0;
        tick();

        // ext_en raised during core 5 read ACCESS: read completes, then EXT.
        set_core(5, 1'b1, 1'b0, 9'd40, '0);
        tick();
        ext_en = 1'b1;
        tick();
        chk("x5_gnt", gnt, 8'h20);
        req[5] = 1'b0;
        tick();
        chk("x5_no_rvalid_yet", rvalid, '0);
        tick();
        chk("x5_rvalid", rvalid, 8'h20);
        chk("x5_rdata", rdata, 16'h5555);
        chk("x5_in_ext", busy, 1'b1);
        ext_we = 1'b1; ext_addr = 9'd1; ext_wdata = 16'h1234;
        #1;
        chk("x_mem_we", mem_we, 1'b1);
        chk("x_mem_addr", mem_addr, 9'd1);
        chk("x_mem_wdata", mem_wdata, 16'h1234);
        tick();
        ext_we = 1'b0; ext_re = 1'b1;
        chk("x_gnt", gnt, '0);
        tick();
        ext_re = 1'b0;
        tick();
        chk("x_rdata", rdata, 16'h1234);
        ext_en = 1'b0;
        tick();
        chk("x_exit", busy, 1'b0);
        do_read(2, 9'd1, 16'h1234);

        // Reset during RESP of core 2 read: no rvalid, reset values next cycle.
        set_core(2, 1'b1, 1'b0, 9'd20, '0);
        tick(); tick();
        chk("r2_gnt", gnt, 8'h04);
        req[2] = 1'b0;
        rst = 1'b1;
        tick();
        chk("r2_rst_gnt", gnt, '0);
        chk("r2_rst_rvalid", rvalid, '0);
        chk("r2_rst_rdata", rdata, '0);
        chk("r2_rst_mem_re", mem_re, 1'b0);
        chk("r2_rst_mem_addr", mem_addr, '0);
        chk("r2_rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        chk("r2_no_rvalid_a", rvalid, '0);
        tick();
        chk("r2_no_rvalid_b", rvalid, '0);

        // All cores request continuously: strict rotation, core 4 once per 8 grants.
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b1, AW'(200 + i), DW'(i));
        c4 = 0;
        for (int g = 0; g < 2 * N; g++) begin
            tick();
            tick();
            chk($sformatf("fair_gnt%0d", g), gnt, N'(1) << (g % N));
            if (gnt[4]) c4++;
        end
        chk("fair_core4_count", c4, 2);
        req = '0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
